// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control block: state encoding,
// button indices and the divider arithmetic used to size the prescalers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SPLIT   = 2'd2,
        STOPPED = 2'd3
    } sw_state_t;

    // Bit positions of the buttons inside the press vector
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_MID   = 2;
    localparam int NUM_BTN   = 3;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_CNT_HZ    = 100;
    localparam int DEF_SAMPLE_HZ = 1000;

    // Clock cycles per event of the given rate
    function automatic int div_ratio(input int clk_hz, input int rate_hz);
        return clk_hz / rate_hz;
    endfunction

    // Counter width able to hold 0..div-1 (never narrower than one bit)
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctl_if.sv
// Front-panel buttons in, counter/display strobes out. The controller takes
// the slave view; the panel/counter side (or a bench) takes the master view.
interface stopwatch_ctl_if;
    logic start;
    logic stop;
    logic midstop;
    logic cnt_en;
    logic cnt_clr;
    logic disp_hold;
    logic running;

    modport master (
        output start, stop, midstop,
        input  cnt_en, cnt_clr, disp_hold, running
    );

    modport slave (
        input  start, stop, midstop,
        output cnt_en, cnt_clr, disp_hold, running
    );
endinterface

// File: rtl/stopwatch_ctl_btn_sampler.sv
// One button channel: 2-FF synchronizer, a flop that only updates on the
// shared sample tick (this is the debounce), and a one-cycle press pulse
// when two consecutive samples go 0 -> 1.
module btn_sampler (
    input  logic clk,
    input  logic srst,
    input  logic sample_tick,
    input  logic btn_raw,
    output logic press
);
    logic sync1_reg;
    logic sync2_reg;
    logic sampled_reg;
    logic press_reg;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Sample at the slow tick and flag a rising sampled level
    always_ff @(posedge clk) begin
        if (srst) begin
            sampled_reg <= 1'b0;
            press_reg   <= 1'b0;
        end else begin
            press_reg <= sample_tick && sync2_reg && !sampled_reg;
            if (sample_tick) begin
                sampled_reg <= sync2_reg;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctl.sv
// Stopwatch control: debounced buttons drive an IDLE/RUN/SPLIT/STOPPED FSM
// which gates a count-rate prescaler and produces count, clear and
// display-hold strobes for the BCD counter and 7-segment driver.
module stopwatch_ctl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int CNT_HZ    = DEF_CNT_HZ,
    parameter int SAMPLE_HZ = DEF_SAMPLE_HZ
) (
    input  logic           clk100MHz,
    input  logic           rst,
    stopwatch_ctl_if.slave bus
);
    localparam int CNT_DIV    = div_ratio(CLK_HZ, CNT_HZ);
    localparam int SAMPLE_DIV = div_ratio(CLK_HZ, SAMPLE_HZ);
    localparam int CNT_W      = div_width(CNT_DIV);
    localparam int SAMPLE_W   = div_width(SAMPLE_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(CNT_DIV - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);

    logic [SAMPLE_W-1:0] sample_cnt_reg;
    logic                sample_tick;
    logic [NUM_BTN-1:0]  btn_raw;
    logic [NUM_BTN-1:0]  press;

    sw_state_t  state_reg;
    sw_state_t  state_next;
    logic       do_start;
    logic       do_stop;
    logic       do_mid;
    logic       cnt_clr_next;
    logic       disp_hold_next;
    logic       running_next;
    logic       run_from_idle;
    logic       cnt_clr_reg;
    logic       disp_hold_reg;
    logic       running_reg;

    logic [CNT_W-1:0] cnt_div_reg;
    logic             cnt_en_reg;
    logic             counting;

    // Shared sample prescaler; tick marks its terminal count
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            sample_cnt_reg <= '0;
        end else if (sample_tick) begin
            sample_cnt_reg <= '0;
        end else begin
            sample_cnt_reg <= sample_cnt_reg + SAMPLE_W'(1);
        end
    end

    assign sample_tick = (sample_cnt_reg == SAMPLE_LAST);

    assign btn_raw[BTN_START] = bus.start;
    assign btn_raw[BTN_STOP]  = bus.stop;
    assign btn_raw[BTN_MID]   = bus.midstop;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_sampler u_sampler (
                .clk         (clk100MHz),
                .srst        (rst),
                .sample_tick (sample_tick),
                .btn_raw     (btn_raw[gi]),
                .press       (press[gi])
            );
        end
    endgenerate

    // Only the highest-priority press of a cycle is acted on
    assign do_stop  = press[BTN_STOP];
    assign do_mid   = press[BTN_MID]   && !press[BTN_STOP];
    assign do_start = press[BTN_START] && !press[BTN_STOP] && !press[BTN_MID];

    // State register with the registered FSM outputs
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_clr_reg   <= 1'b0;
            disp_hold_reg <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_clr_reg   <= cnt_clr_next;
            disp_hold_reg <= disp_hold_next;
            running_reg   <= running_next;
        end
    end

    // Next-state decode from the arbitrated press
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (do_start) state_next = RUN;
            end
            RUN: begin
                if (do_stop)     state_next = STOPPED;
                else if (do_mid) state_next = SPLIT;
            end
            SPLIT: begin
                if (do_stop)       state_next = STOPPED;
                else if (do_start) state_next = RUN;
            end
            STOPPED: begin
                if (do_stop)       state_next = IDLE;
                else if (do_start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; levels follow the state being entered so they change on the same edge
    always_comb begin
        cnt_clr_next   = do_stop && ((state_reg == IDLE) || (state_reg == STOPPED));
        disp_hold_next = (state_next == SPLIT);
        running_next   = (state_next == RUN) || (state_next == SPLIT);
        run_from_idle  = (state_reg == IDLE) && (state_next == RUN);
    end

    assign counting = (state_reg == RUN) || (state_reg == SPLIT);

    // Count-rate prescaler: runs in RUN/SPLIT, holds in STOPPED, restarts on clear or fresh start
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            cnt_div_reg <= '0;
            cnt_en_reg  <= 1'b0;
        end else begin
            cnt_en_reg <= counting && (cnt_div_reg == CNT_LAST);
            if (cnt_clr_next || run_from_idle) begin
                cnt_div_reg <= '0;
            end else if (counting) begin
                cnt_div_reg <= (cnt_div_reg == CNT_LAST) ? '0 : cnt_div_reg + CNT_W'(1);
            end
        end
    end

    assign bus.cnt_en    = cnt_en_reg;
    assign bus.cnt_clr   = cnt_clr_reg;
    assign bus.disp_hold = disp_hold_reg;
    assign bus.running   = running_reg;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Bench for stopwatch_ctl with a scaled clock (10 cycles per ms). A reference
// model turns button activity into expected output events queued per cycle;
// a monitor pops and compares whenever the DUT shows an event.
module tb_stopwatch_ctl;
    localparam int CLK_HZ     = 10_000;
    localparam int CNT_HZ     = 100;
    localparam int SAMPLE_HZ  = 1000;
    localparam int CNT_DIV    = CLK_HZ / CNT_HZ;     // 100 cycles per count
    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;  // 10 cycles per sample
    localparam int MS         = CLK_HZ / 1000;       // cycles per millisecond

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctl_if sw_if ();

    stopwatch_ctl #(
        .CLK_HZ    (CLK_HZ),
        .CNT_HZ    (CNT_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) dut (
        .clk100MHz (clk),
        .rst       (rst),
        .bus       (sw_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic en;
        logic clr;
        logic hold;
        logic run;
    } ev_t;
    ev_t exp_q[$];

    int cyc = 0;   // posedge count, stamps events
    int m_e = 0;   // edges since last reset, gives sample-tick phase
    bit mon_on = 0;
    int n_en = 0;
    int n_clr = 0;
    int last_rise = 0;
    int first_en = -1;

    typedef enum {M_IDLE, M_RUN, M_SPLIT, M_STOPPED} m_state_t;

    // Reference model: panel behaviour in terms of sample instants and elapsed run time
    initial begin : model
        m_state_t   st = M_IDLE;
        int         run_time = 0;
        logic [2:0] pend = '0;     // presses due to act on the next edge
        logic [2:0] last_smp = '0; // level seen at previous sample instant
        logic [2:0] seen1 = '0;    // raw level one edge ago
        logic [2:0] seen2 = '0;    // raw level two edges ago
        logic [2:0] raw;
        logic en, clr, hold, run;
        logic p_hold = 1'b0;
        logic p_run = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            raw = {sw_if.midstop, sw_if.stop, sw_if.start};
            en  = 1'b0;
            clr = 1'b0;
            if (rst) begin
                st = M_IDLE; run_time = 0; pend = '0; last_smp = '0;
                seen1 = '0; seen2 = '0; m_e = 0;
            end else begin
                m_e++;
                if (st == M_RUN || st == M_SPLIT) begin
                    run_time++;
                    if (run_time == CNT_DIV) begin
                        run_time = 0;
                        en = 1'b1;
                    end
                end
                if (pend[1]) begin
                    if (st == M_IDLE || st == M_STOPPED) begin
                        clr = 1'b1;
                        st = M_IDLE;
                        run_time = 0;
                    end else begin
                        st = M_STOPPED;
                    end
                end else if (pend[2]) begin
                    if (st == M_RUN) st = M_SPLIT;
                end else if (pend[0]) begin
                    if (st == M_IDLE) run_time = 0;
                    st = M_RUN;
                end
                pend = '0;
                if (m_e % SAMPLE_DIV == 0) begin
                    pend     = seen2 & ~last_smp;
                    last_smp = seen2;
                end
                seen2 = seen1;
                seen1 = raw;
            end
            hold = (st == M_SPLIT);
            run  = (st == M_RUN) || (st == M_SPLIT);
            if (en || clr || hold != p_hold || run != p_run)
                exp_q.push_back(ev_t'{cyc, en, clr, hold, run});
            p_hold = hold;
            p_run  = run;
        end
    end

    // Monitor: compares each DUT output event with the queued expectation
    initial begin : monitor
        logic p_hold = 1'b0;
        logic p_run = 1'b0;
        logic ev;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event cyc=%0d got no event required en=%b clr=%b hold=%b run=%b",
                             e.cyc, e.en, e.clr, e.hold, e.run);
                end
                ev = (sw_if.cnt_en === 1'b1) || (sw_if.cnt_clr === 1'b1) ||
                     (sw_if.disp_hold !== p_hold) || (sw_if.running !== p_run);
                if (ev) begin
                    checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d got en=%b clr=%b hold=%b run=%b required no event",
                                 cyc, sw_if.cnt_en, sw_if.cnt_clr, sw_if.disp_hold, sw_if.running);
                    end else begin
                        e = exp_q.pop_front();
                        if (sw_if.cnt_en !== e.en || sw_if.cnt_clr !== e.clr ||
                            sw_if.disp_hold !== e.hold || sw_if.running !== e.run) begin
                            errors++;
                            $display("FAIL event_value cyc=%0d got en=%b clr=%b hold=%b run=%b required en=%b clr=%b hold=%b run=%b",
                                     cyc, sw_if.cnt_en, sw_if.cnt_clr, sw_if.disp_hold, sw_if.running,
                                     e.en, e.clr, e.hold, e.run);
                        end
                    end
                end
                if (sw_if.running === 1'b1 && p_run === 1'b0) begin
                    last_rise = cyc;
                    first_en  = -1;
                end
                if (sw_if.cnt_en === 1'b1) begin
                    n_en++;
                    if (first_en < 0) first_en = cyc;
                end
                if (sw_if.cnt_clr === 1'b1) n_clr++;
            end
            p_hold = sw_if.disp_hold;
            p_run  = sw_if.running;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       sw_if.start   = v;
            1:       sw_if.stop    = v;
            default: sw_if.midstop = v;
        endcase
    endtask

    task automatic hold_btn(input int b, input int n);
        set_btn(b, 1'b1);
        wait_cyc(n);
        set_btn(b, 1'b0);
    endtask

    // Directed scenarios followed by a randomized soak
    initial begin : stim
        int base;
        int base_clr;
        sw_if.start   = 1'b0;
        sw_if.stop    = 1'b0;
        sw_if.midstop = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        wait_cyc(1);
        check("reset_cnt_en",    sw_if.cnt_en,    0);
        check("reset_cnt_clr",   sw_if.cnt_clr,   0);
        check("reset_disp_hold", sw_if.disp_hold, 0);
        check("reset_running",   sw_if.running,   0);
        rst = 1'b0;
        mon_on = 1;

        wait_cyc(20 * MS);
        check("idle_no_cnt_en", n_en, 0);

        // Start, then count for 500 ms
        base = n_en;
        hold_btn(0, 10 * MS);
        wait_cyc(500 * MS);
        check("run_running", sw_if.running, 1);
        check("run_pulse_count", n_en - base, 50);
        check("run_first_pulse_delay", first_en - last_rise, CNT_DIV);

        // Split keeps counting with the display frozen
        hold_btn(2, 10 * MS + $urandom_range(0, 5));
        wait_cyc(30 * MS);
        check("split_disp_hold", sw_if.disp_hold, 1);
        check("split_running", sw_if.running, 1);
        base = n_en;
        wait_cyc(100 * MS);
        check("split_pulse_count", n_en - base, 10);
        hold_btn(0, 10 * MS + $urandom_range(0, 5));
        wait_cyc(30 * MS);
        check("unsplit_disp_hold", sw_if.disp_hold, 0);
        check("unsplit_running", sw_if.running, 1);

        // Stop holds the count
        hold_btn(1, 10 * MS);
        base = n_en;
        wait_cyc(500 * MS);
        check("stopped_running", sw_if.running, 0);
        check("stopped_no_cnt_en", n_en - base, 0);

        // Resume, then stop twice
        hold_btn(0, 10 * MS + $urandom_range(0, 7));
        wait_cyc(30 * MS);
        check("resume_running", sw_if.running, 1);
        base_clr = n_clr;
        hold_btn(1, 10 * MS);
        wait_cyc(5 * MS);
        hold_btn(1, 10 * MS);
        wait_cyc(5 * MS);
        check("stop_twice_clr_count", n_clr - base_clr, 1);
        check("stop_twice_running", sw_if.running, 0);

        // start and stop together from IDLE: stop wins
        base_clr = n_clr;
        sw_if.start = 1'b1;
        sw_if.stop  = 1'b1;
        wait_cyc(10 * MS);
        sw_if.start = 1'b0;
        sw_if.stop  = 1'b0;
        wait_cyc(5 * MS);
        check("start_stop_clr_count", n_clr - base_clr, 1);
        check("start_stop_running", sw_if.running, 0);

        // Short start glitch kept clear of a sample instant
        for (int i = 0; i <= SAMPLE_DIV && (m_e % SAMPLE_DIV) != 1; i++) wait_cyc(1);
        hold_btn(0, 3);
        wait_cyc(5 * MS);
        check("glitch_running", sw_if.running, 0);

        // Reset while in SPLIT
        hold_btn(0, 10 * MS);
        wait_cyc(3 * MS);
        hold_btn(2, 10 * MS);
        wait_cyc(3 * MS);
        check("pre_reset_disp_hold", sw_if.disp_hold, 1);
        base_clr = n_clr;
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("rst_split_disp_hold", sw_if.disp_hold, 0);
        check("rst_split_running", sw_if.running, 0);
        check("rst_split_cnt_clr", n_clr - base_clr, 0);
        hold_btn(0, 10 * MS);
        wait_cyc(3 * MS);
        check("restart_after_rst", sw_if.running, 1);

        // Randomized soak: bounce, overlapping presses, occasional reset
        for (int it = 0; it < 150; it++) begin
            int b;
            int r;
            int nb;
            b = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1;
                wait_cyc($urandom_range(1, 3));
                rst = 1'b0;
            end else if (r < 10) begin
                set_btn(b, 1'b1);
                set_btn((b + 1) % 3, 1'b1);
                wait_cyc($urandom_range(1, 4 * MS));
                set_btn(b, 1'b0);
                set_btn((b + 1) % 3, 1'b0);
            end else begin
                if (r < 40) begin
                    nb = $urandom_range(1, 4);
                    for (int k = 0; k < nb; k++) begin
                        set_btn(b, 1'($urandom_range(0, 1)));
                        wait_cyc(1);
                    end
                end
                hold_btn(b, $urandom_range(1, 8 * MS));
            end
            wait_cyc($urandom_range(1, 30 * MS));
        end
        wait_cyc(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctl.md
Name: stopwatch_ctl

Overview:
Control FSM that sequences the stopwatch counter/display datapath from the three front-panel buttons: start, stop and midstop (split/lap). It samples and debounces the raw buttons and divides clk100MHz down to the count rate. It emits count-enable, clear and display-hold strobes to the BCD counter and the 7-segment driver. It sits between the top-level button pins and the counter inside stopwatch.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
CNT_HZ, 100, count rate (hundredths of a second); CNT_DIV = CLK_HZ/CNT_HZ
SAMPLE_HZ, 1000, button sampling rate; SAMPLE_DIV = CLK_HZ/SAMPLE_HZ

Ports:
clk100MHz  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  raw start button, asynchronous, active-high
stop  in  1  raw stop button, asynchronous, active-high
midstop  in  1  raw split button, asynchronous, active-high
cnt_en  out  1  one-cycle pulse; counter advances by one LSB
cnt_clr  out  1  one-cycle pulse; counter clears to 0000
disp_hold  out  1  level; display latch freezes its current value while high
running  out  1  level; high in RUN and SPLIT

Behaviour:
- Reset: all outputs 0, state IDLE, both prescalers 0, synchronizer and sample flops 0.
- Button path, per input:
  - 2-FF synchronizer.
  - Sample prescaler counts 0..SAMPLE_DIV-1; sample_tick is high at terminal count.
  - On sample_tick, the sampled flop loads the synchronized level.
  - press is a one-cycle pulse in the cycle after a sample where the level went 0->1.
  - Glitches shorter than one sample period, and release bounce, produce at most one press per 0->1 sampled transition.
  - Holding a button produces exactly one press.
- Press priority within one cycle: stop > midstop > start. Only the highest-priority press acts; the others are dropped.
- FSM (state register updates on the clock edge after press):
  - IDLE: start -> RUN. stop -> IDLE, pulsing cnt_clr. midstop ignored.
  - RUN: stop -> STOPPED. midstop -> SPLIT. start ignored.
  - SPLIT: start -> RUN (releases freeze; count continues, no lost pulses). midstop ignored. stop -> STOPPED.
  - STOPPED: start -> RUN (resume from held value). stop -> IDLE, pulsing cnt_clr. midstop ignored.
- Count prescaler:
  - Counts 0..CNT_DIV-1 only in RUN/SPLIT; holds its value in STOPPED.
  - Cleared to 0 on cnt_clr and on the IDLE->RUN transition.
  - cnt_en = registered pulse at terminal count while in RUN/SPLIT. With defaults the first pulse comes exactly 1_000_000 cycles after entering RUN from IDLE.
- disp_hold = 1 exactly while in SPLIT (registered output; it rises on the same edge the state enters SPLIT).
- Leaving SPLIT via stop: disp_hold drops and the display shows the final stopped count.
- cnt_clr is a registered one-cycle pulse on the edge that processes the stop press. cnt_en is never high in the same cycle as cnt_clr.
- Press-to-output latency: at most 2 (sync) + SAMPLE_DIV + 2 cycles from the raw edge.
- rst mid-operation: returns to IDLE on the next edge. cnt_clr is not pulsed; the counter has its own reset.

Decomposition:
- stopwatch_pkg:
  - State enum sw_state_t {IDLE, RUN, SPLIT, STOPPED} (2-bit).
  - Functions/constants for CNT_DIV, SAMPLE_DIV and their $clog2 widths.
- Sub-module btn_sampler: synchronizer + sampled flop + rising-edge press output, with the shared sample_tick as input. It is instantiated three times.
- One sample prescaler is shared by all three btn_sampler instances.

Test Plan:
- rst held 2 cycles -> cnt_en, cnt_clr, disp_hold, running all 0; no cnt_en over 20 ms of idle.
- start held 10 ms, then 500 ms wait -> running=1; exactly 50 cnt_en pulses 10 ms apart, the first exactly 1_000_000 cycles after the state enters RUN.
- In RUN, midstop held 10 ms -> disp_hold=1, cnt_en keeps pulsing every 10 ms.
  - Then start held 10 ms -> disp_hold=0, running=1, no gap in the cnt_en period.
- In RUN, stop held 10 ms -> running=0, no cnt_en for 500 ms.
  - Then start -> next cnt_en comes at the remaining prescaler count (resume).
  - Stop twice from RUN -> exactly one cnt_clr pulse, state IDLE.
- start and stop asserted in the same cycle from IDLE -> stop wins: one cnt_clr, still IDLE, running=0.
  - 200 ns glitch on start placed between sample ticks -> no press, no state change.
- rst asserted in SPLIT -> next edge disp_hold=0, running=0, no cnt_clr pulse; a subsequent start works normally.
